duty_ramp: RTL and testbench
============================

DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the duty/PWM resolution in bits.
REQ-002 The block SHALL have parameter IW, default 8, giving the interval width in bits.
REQ-003 The block SHALL have port clk_i, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port valid_i, input, 1 bit: the command is valid.
REQ-006 The block SHALL have port ready_o, output, 1 bit: the block can accept a command.
REQ-007 The block SHALL have port target_i, input, WIDTH bits: the final duty value.
REQ-008 The block SHALL have port step_i, input, WIDTH bits: the duty increment per step.
REQ-009 The block SHALL have port interval_i, input, IW bits: the number of PWM periods between steps.
REQ-010 The block SHALL have port duty_o, output, WIDTH bits: the registered duty, driving a downstream pwm duty input.
REQ-011 The block SHALL have port busy_o, output, 1 bit: a ramp is in progress.
REQ-012 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse when the ramp completes.

Function
REQ-013 The block SHALL contain a free-running WIDTH-bit period counter.
- It increments every cycle, including in IDLE, and wraps from 2^WIDTH-1 to 0.
- It is phase-aligned with a downstream pwm sharing clk_i and rst_n.
REQ-014 Period end (PE) SHALL be the cycle in which the period counter equals 2^WIDTH-1.
REQ-015 The FSM SHALL have exactly two states, IDLE and RAMP.
- ready_o=1 only in IDLE.
- busy_o=1 only in RAMP.
REQ-016 A command SHALL be accepted when valid_i=1 and ready_o=1 on a clock edge.
- The block latches target_i, step_i and interval_i.
- It clears the interval counter and enters RAMP.
REQ-017 Latched step=0 SHALL be treated as 1, and latched interval=0 SHALL be treated as 1.
REQ-018 valid_i asserted while in RAMP SHALL be ignored, and latched values SHALL NOT change.
REQ-019 In RAMP, the IW-bit interval counter SHALL increment on each PE.
- A step event occurs on a PE where the interval counter equals interval-1.
- The interval counter clears to 0 on each step event.
REQ-020 On a step event with duty_o<target, duty_o SHALL become min(duty_o+step, target), computed in WIDTH+1 bits with no wrap.
REQ-021 On a step event with duty_o>target, duty_o SHALL become max(duty_o-step, target), with no underflow.
REQ-022 duty_o SHALL change only on the clock edge ending a PE cycle.
- The new duty therefore takes effect from period-counter value 0 of the next PWM period.
- No mid-period glitch is allowed.
REQ-023 In RAMP, when duty_o equals the latched target, the FSM SHALL go to IDLE on the next edge.
- done_o=1 for exactly that following cycle.
- ready_o=1 in that same cycle.
REQ-024 An accepted target equal to the current duty_o SHALL produce done_o exactly 2 cycles after the accepting edge, with duty_o unchanged.
REQ-025 A new command SHALL be acceptable in the cycle done_o=1.
REQ-026 In IDLE, duty_o SHALL hold its last value indefinitely.

Reset
REQ-027 While rst_n=0, the block SHALL hold these values asynchronously:
- duty_o=0, ready_o=1, busy_o=0, done_o=0
- state=IDLE
- period counter=0, interval counter=0
- latched target/step/interval=0
REQ-028 Reset asserted mid-ramp SHALL abort the ramp immediately, with no done_o pulse.
REQ-029 After rst_n deasserts, the block SHALL resume at period count 0 on the first clock edge.

Verification
REQ-030 The bench SHALL cover these directed scenarios, each with WIDTH=4 (period 16 clocks):
- Up ramp: from duty 0, accept target=10, step=3, interval=1 -> duty_o goes 3,6,9,10 at four consecutive PEs; then done_o pulses once; then ready_o=1.
- Down ramp: from duty 10, accept target=2, step=5, interval=2 -> duty_o goes 5 then 2, one change every 2 PWM periods (32 clocks); then done_o pulses.
- Boundary: from duty 0, accept target=15, step=15 -> duty_o=15 at the first PE, no overflow. Then target=0, step=0 -> duty_o decrements by 1 per period to 0.
- Busy ignore: during a ramp, assert valid_i with target=7 -> the latched target is unchanged, ready_o stays 0, and the ramp ends at the original target.
- Equal target: duty 5, accept target=5 -> done_o pulses exactly 2 cycles after the accept edge, and duty_o stays 5.
- Reset mid-ramp: pulse rst_n low during RAMP at duty 6 -> duty_o=0, ready_o=1, busy_o=0 immediately, with no done_o pulse.

Source files
------------

// File: rtl/duty_ramp.sv
// -----------------------------------------------------------------------------
// duty_ramp
//
// Walks a PWM duty value from its current setting toward a commanded target,
// one step at a time. Steps land only on PWM period boundaries, so a
// downstream pwm that shares clk_i/rst_n never sees a duty change mid-period.
//
// A free-running WIDTH-bit period counter mirrors the phase of that
// downstream pwm. Period end (PE) is the cycle in which the counter reads
// all-ones. Every PE seen while ramping advances an interval counter. When
// the interval counter reaches the latched interval, that PE becomes a step
// event and duty_o moves by the latched step. The move is clamped at the
// target in both directions.
//
// Parameters
//   WIDTH : duty / period-counter resolution in bits
//   IW    : interval (PWM periods per step) width in bits
//
// Ports
//   clk_i            in   clock; every state change is on its rising edge
//   rst_n            in   asynchronous active-low reset
//   valid_i          in   command valid
//   ready_o          out  block can accept a command (IDLE)
//   target_i         in   final duty value of the commanded ramp
//   step_i           in   duty increment per step (0 acts as 1)
//   interval_i       in   PWM periods between steps (0 acts as 1)
//   duty_o           out  registered duty for the downstream pwm
//   busy_o           out  ramp in progress (RAMP)
//   done_o           out  one-cycle pulse as the ramp completes
//   dbg_state        out  FSM state (0 = IDLE, 1 = RAMP)
//   dbg_period       out  period counter value
//   dbg_interval_cnt out  interval counter value
// -----------------------------------------------------------------------------
module duty_ramp #(
   parameter int WIDTH = 8,
   parameter int IW    = 8
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] target_i,
   input  logic [WIDTH-1:0] step_i,
   input  logic [IW-1:0]    interval_i,
   output logic [WIDTH-1:0] duty_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             dbg_state,
   output logic [WIDTH-1:0] dbg_period,
   output logic [IW-1:0]    dbg_interval_cnt
);

   localparam logic [WIDTH-1:0] W_ONE  = WIDTH'(1);
   localparam logic [IW-1:0]    IW_ONE = IW'(1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] period_cnt;
   logic [IW-1:0]    interval_cnt;
   logic [WIDTH-1:0] target_q;
   logic [WIDTH-1:0] step_q;
   logic [IW-1:0]    interval_q;

   logic             pe;
   logic             accept;
   logic             at_target;
   logic             ramp_pe;
   logic             step_evt;
   logic [IW-1:0]    interval_last;
   logic [WIDTH:0]   sum_wide;
   logic [WIDTH-1:0] dist_down;
   logic [WIDTH-1:0] duty_up;
   logic [WIDTH-1:0] duty_down;
   logic [WIDTH-1:0] duty_step;

   // Handshake: a command transfers on a rising edge where valid_i and
   // ready_o are both 1. ready_o depends only on state, never on valid_i.
   // The command fields are sampled on that edge alone. A valid_i held
   // during RAMP has no effect and is not queued.
   assign accept = valid_i && ready_o;

   // ---------------------------------------------------------------------
   // Period counter: free running, including in IDLE, so its phase always
   // matches the downstream pwm.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + W_ONE;
      end
   end

   assign pe = (period_cnt == {WIDTH{1'b1}});

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // Reaching the target always wins over a coincident step event. A ramp
   // whose target already equals duty_o therefore finishes one cycle after
   // the accept, with duty_o untouched.
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (valid_i)   state_nxt = ST_RAMP;
         ST_RAMP: if (at_target) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      ready_o = 1'b0;
      busy_o  = 1'b0;
      case (state)
         ST_IDLE: ready_o = 1'b1;
         ST_RAMP: busy_o  = 1'b1;
         default: ready_o = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------
   // Command latch. Zero step or interval would stall the ramp forever, so
   // both are promoted to 1 as they are captured.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         target_q   <= '0;
         step_q     <= '0;
         interval_q <= '0;
      end else if (accept) begin
         target_q   <= target_i;
         step_q     <= (step_i == '0) ? W_ONE : step_i;
         interval_q <= (interval_i == '0) ? IW_ONE : interval_i;
      end
   end

   // ---------------------------------------------------------------------
   // Step timing. PEs are counted only while there is still distance to
   // cover. The counter restarts on every step event, so consecutive steps
   // are exactly interval_q periods apart.
   // ---------------------------------------------------------------------
   assign at_target     = (duty_o == target_q);
   assign ramp_pe       = (state == ST_RAMP) && !at_target && pe;
   assign interval_last = interval_q - IW_ONE;
   assign step_evt      = ramp_pe && (interval_cnt == interval_last);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         interval_cnt <= '0;
      end else if (accept) begin
         interval_cnt <= '0;
      end else if (ramp_pe) begin
         if (step_evt) begin
            interval_cnt <= '0;
         end else begin
            interval_cnt <= interval_cnt + IW_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Duty arithmetic. Upward moves use one extra bit so that a large step
   // cannot wrap past the top of the range before the clamp. Downward moves
   // compare the step with the remaining distance (duty_o - target_q). That
   // distance is only used when duty_o > target_q, so it cannot underflow.
   // ---------------------------------------------------------------------
   assign sum_wide  = {1'b0, duty_o} + {1'b0, step_q};
   assign duty_up   = (sum_wide > {1'b0, target_q}) ? target_q
                                                    : sum_wide[WIDTH-1:0];
   assign dist_down = duty_o - target_q;
   assign duty_down = (step_q >= dist_down) ? target_q : (duty_o - step_q);
   assign duty_step = (duty_o < target_q) ? duty_up : duty_down;

   // duty_o moves only on the edge that closes a PE cycle. The new value is
   // therefore first seen at period count 0 of the next PWM period.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         duty_o <= '0;
      end else if (step_evt) begin
         duty_o <= duty_step;
      end
   end

   // done_o is high in the first IDLE cycle after a completed ramp. Reset
   // clears it, so an aborted ramp never pulses it.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         done_o <= 1'b0;
      end else begin
         done_o <= (state == ST_RAMP) && at_target;
      end
   end

   assign dbg_state        = state;
   assign dbg_period       = period_cnt;
   assign dbg_interval_cnt = interval_cnt;

endmodule

// File: tb/tb_duty_ramp.sv
// -----------------------------------------------------------------------------
// tb_duty_ramp
//
// Bench for duty_ramp with WIDTH=4 (16-clock PWM period) and IW=8.
// The reference model tracks the ramp as whole numbers. Each edge it
// accepts a command, finishes a ramp, or counts a period end and moves the
// duty by the min/max rule. The expected duty sequence of each directed
// ramp is also worked out ahead of time into exp_q.
// -----------------------------------------------------------------------------
module tb_duty_ramp;

   localparam int W   = 4;
   localparam int IW  = 8;
   localparam int PER = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid = 1'b0;
   logic [W-1:0]  target = '0;
   logic [W-1:0]  step = '0;
   logic [IW-1:0] interval = '0;
   logic          ready;
   logic [W-1:0]  duty;
   logic          busy;
   logic          done;
   logic          dbg_state;
   logic [W-1:0]  dbg_period;
   logic [IW-1:0] dbg_interval_cnt;

   duty_ramp #(.WIDTH(W), .IW(IW)) dut (
      .clk_i            (clk),
      .rst_n            (rst_n),
      .valid_i          (valid),
      .ready_o          (ready),
      .target_i         (target),
      .step_i           (step),
      .interval_i       (interval),
      .duty_o           (duty),
      .busy_o           (busy),
      .done_o           (done),
      .dbg_state        (dbg_state),
      .dbg_period       (dbg_period),
      .dbg_interval_cnt (dbg_interval_cnt)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exhausted, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_cnt, m_duty, m_tgt, m_step, m_itv, m_pes;
   bit m_busy, m_done;

   function automatic int ramp_next(input int d, input int t, input int s);
      if (d < t) return (d + s > t) ? t : d + s;
      else       return (d - s < t) ? t : d - s;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_duty = 0; m_tgt = 0; m_step = 0; m_itv = 0; m_pes = 0;
      m_busy = 0; m_done = 0;
   endtask

   task automatic model_edge();
      bit pe;
      bit nxt_done;
      pe = (m_cnt == PER - 1);
      nxt_done = 0;
      if (!m_busy) begin
         if (valid) begin
            m_tgt  = int'(target);
            m_step = (step == 0) ? 1 : int'(step);
            m_itv  = (interval == 0) ? 1 : int'(interval);
            m_pes  = 0;
            m_busy = 1;
         end
      end else if (m_duty == m_tgt) begin
         m_busy   = 0;
         nxt_done = 1;
      end else if (pe) begin
         m_pes++;
         if (m_pes == m_itv) begin
            m_pes  = 0;
            m_duty = ramp_next(m_duty, m_tgt, m_step);
         end
      end
      m_done = nxt_done;
      m_cnt  = (m_cnt + 1) % PER;
   endtask

   task automatic check_outputs();
      chk("duty", int'(duty), m_duty);
      chk("ready", int'(ready), int'(!m_busy));
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("state", int'(dbg_state), int'(m_busy));
      chk("period", int'(dbg_period), m_cnt);
      chk("interval_cnt", int'(dbg_interval_cnt), m_pes);
   endtask

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_outputs();
   endtask

   task automatic drive_cmd(input int t, input int s, input int iv);
      valid    = 1'b1;
      target   = W'(t);
      step     = W'(s);
      interval = IW'(iv);
   endtask

   task automatic wait_done(input string name, input int limit);
      bit seen;
      seen = 0;
      for (int n = 0; n < limit && !seen; n++) begin
         tick();
         if (done) seen = 1;
      end
      if (!seen) chk({name, "_timeout"}, 0, 1);
   endtask

   // ---------------- directed command table ----------------
   typedef struct {
      int tgt;
      int stp;
      int itv;
      int n_chg;
      int first;
      int gap;
   } cmd_t;

   cmd_t tbl[5];

   task automatic run_cmd(input cmd_t c);
      int prev, changes, first, gap, last_n, s, d;
      bit seen;
      exp_q.delete();
      s = (c.stp == 0) ? 1 : c.stp;
      d = m_duty;
      while (d != c.tgt) begin
         d = ramp_next(d, c.tgt, s);
         exp_q.push_back(W'(d));
      end
      drive_cmd(c.tgt, c.stp, c.itv);
      tick();
      valid = 1'b0;
      chk("cmd_accept_busy", int'(busy), 1);
      prev = int'(duty); changes = 0; first = 0; gap = 0; last_n = 0; seen = 0;
      for (int n = 1; n <= 2000 && !seen; n++) begin
         tick();
         if (int'(duty) != prev) begin
            changes++;
            if (exp_q.size() == 0) chk("ramp_extra_step", int'(duty), prev);
            else chk("ramp_seq", int'(duty), int'(exp_q.pop_front()));
            chk("ramp_pe_align", int'(dbg_period), 0);
            if (changes == 1) first = int'(duty);
            else gap = n - last_n;
            last_n = n;
            prev = int'(duty);
         end
         if (done) seen = 1;
      end
      if (!seen) chk("ramp_timeout", 0, 1);
      chk("ramp_changes", changes, c.n_chg);
      chk("ramp_first", first, c.first);
      chk("ramp_gap", gap, c.gap);
      chk("ramp_final", int'(duty), c.tgt);
      chk("ramp_left_over", exp_q.size(), 0);
      tick();
      chk("ramp_done_once", int'(done), 0);
   endtask

   // ---------------- test ----------------
   initial begin
      tbl[0] = '{tgt: 15, stp: 15, itv: 1, n_chg: 1,  first: 15, gap: 0};
      tbl[1] = '{tgt: 0,  stp: 0,  itv: 0, n_chg: 15, first: 14, gap: 16};
      tbl[2] = '{tgt: 10, stp: 3,  itv: 1, n_chg: 4,  first: 3,  gap: 16};
      tbl[3] = '{tgt: 2,  stp: 5,  itv: 2, n_chg: 2,  first: 5,  gap: 32};
      tbl[4] = '{tgt: 5,  stp: 3,  itv: 1, n_chg: 1,  first: 5,  gap: 0};

      // Reset state, held across a few edges.
      model_reset();
      #1;
      check_outputs();
      chk("reset_ready", int'(ready), 1);
      chk("reset_duty", int'(duty), 0);
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick();

      // Directed ramps: boundary up/down, up ramp, down ramp, setup for equal.
      for (int i = 0; i < 5; i++) run_cmd(tbl[i]);

      // Equal target: done_o two cycles after the accept edge, duty_o held.
      drive_cmd(5, 1, 1);
      tick();
      valid = 1'b0;
      chk("eq_c1_done", int'(done), 0);
      chk("eq_c1_busy", int'(busy), 1);
      tick();
      chk("eq_c2_done", int'(done), 1);
      chk("eq_c2_ready", int'(ready), 1);
      chk("eq_c2_duty", int'(duty), 5);
      // New command accepted in the done cycle.
      drive_cmd(6, 1, 1);
      tick();
      valid = 1'b0;
      chk("done_cycle_accept", int'(busy), 1);
      chk("done_cycle_done", int'(done), 0);
      wait_done("to6", 100);
      chk("to6_duty", int'(duty), 6);
      tick();

      // Busy ignore: valid_i held with target 7 across a period end.
      drive_cmd(12, 2, 1);
      tick();
      drive_cmd(7, 1, 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("ignore_ready", int'(ready), 0);
      end
      valid = 1'b0;
      wait_done("ignore", 200);
      chk("ignore_final", int'(duty), 12);
      tick();

      // Reset mid-ramp at duty 6: immediate clear, no done pulse.
      drive_cmd(0, 3, 1);
      tick();
      valid = 1'b0;
      for (int i = 0; i < 200 && int'(duty) != 6; i++) tick();
      chk("pre_reset_duty", int'(duty), 6);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_duty", int'(duty), 0);
      chk("rst_ready", int'(ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_period", int'(dbg_period), 0);
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) tick();

      // Random commands checked cycle by cycle against the model.
      for (int i = 0; i < 1500; i++) begin
         valid    = ($urandom_range(0, 7) == 0);
         target   = W'($urandom_range(0, 15));
         step     = W'($urandom_range(0, 15));
         interval = IW'($urandom_range(0, 2));
         tick();
      end
      valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
